mv_mult_sched: RTL and testbench

Sequencing controller for the matrix-vector multiply datapath. It accepts an NxN coefficient matrix and an N-element vector as a byte-serial valid/ready stream, then computes the products with one shared multiply-accumulate unit, one product per cycle. Each row's dot product is emitted on a valid/ready result port. It sits between the input-switch bus and the result/display logic, so the multiply resource can be reused without a full parallel array.

---
 rtl/mv_mult_sched.sv | 141 ++++++++++++++
 tb/tb_mv_mult_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mv_mult_sched.sv
// Matrix-vector multiply sequencer: streams in an NxN matrix and an N-vector,
// then computes one row dot product at a time on a single shared MAC.
module mv_mult_sched #(
    parameter int N = 2,
    parameter int W = 4,
    localparam int ACC_W = 2*W + $clog2(N),
    localparam int IW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_mat,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    output logic [IW-1:0]    res_idx,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    localparam int KW = $clog2(N*N);
    localparam logic [KW-1:0] K_LAST = KW'(N*N - 1);
    localparam logic [IW-1:0] C_LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, MAC, OUT} state_t;

    state_t state, state_next;

    logic [W-1:0]     mat [N*N];
    logic [W-1:0]     vec [N];
    logic [KW-1:0]    cnt;
    logic [IW-1:0]    col;
    logic [IW-1:0]    row;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [2*W-1:0]   prod;

    // cnt walks the row-major matrix index during MAC, so no row*N multiply is needed
    assign prod    = {{W{1'b0}}, mat[cnt]} * {{W{1'b0}}, vec[col]};
    assign acc_sum = acc + {{(ACC_W-2*W){1'b0}}, prod};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = load_mat ? LOAD_M : LOAD_V;
            end
            LOAD_M: begin
                in_ready = 1'b1;
                if (in_valid && cnt == K_LAST) state_next = LOAD_V;
            end
            LOAD_V: begin
                in_ready = 1'b1;
                if (in_valid && col == C_LAST) state_next = MAC;
            end
            MAC: begin
                if (col == C_LAST) state_next = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = (row == C_LAST) ? IDLE : MAC;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N*N; i++) mat[i] <= '0;
            for (int i = 0; i < N; i++)   vec[i] <= '0;
            cnt      <= '0;
            col      <= '0;
            row      <= '0;
            acc      <= '0;
            res_data <= '0;
            res_idx  <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == OUT) && res_ready && (row == C_LAST);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        col <= '0;
                    end
                end
                LOAD_M: begin
                    if (in_valid) begin
                        mat[cnt] <= in_data;
                        cnt      <= (cnt == K_LAST) ? '0 : cnt + 1'b1;
                    end
                end
                LOAD_V: begin
                    if (in_valid) begin
                        vec[col] <= in_data;
                        if (col == C_LAST) begin
                            col <= '0;
                            row <= '0;
                            cnt <= '0;
                            acc <= '0;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                MAC: begin
                    cnt <= cnt + 1'b1;
                    if (col == C_LAST) begin
                        res_data <= acc_sum;
                        res_idx  <= row;
                        acc      <= '0;
                        col      <= '0;
                    end else begin
                        acc <= acc_sum;
                        col <= col + 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready && row != C_LAST) begin
                        row <= row + 1'b1;
                        col <= '0;
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mv_mult_sched.sv
// Directed bench for mv_mult_sched (N=2, W=4): hand-computed dot products,
// handshake timing, backpressure, mid-operation reset and ignored inputs.
module tb_mv_mult_sched;

    localparam int N = 2;
    localparam int W = 4;
    localparam int ACC_W = 2*W + $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             load_mat = 1'b0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready;
    logic             res_valid;
    logic [ACC_W-1:0] res_data;
    logic [0:0]       res_idx;
    logic             res_ready = 1'b0;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] stim [0:7];
    int cyc;

    mv_mult_sched #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_mat(load_mat),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic startOp(input logic lm);
        start = 1'b1;
        load_mat = lm;
        tick();
        start = 1'b0;
        load_mat = 1'b0;
        checkOutput("busy after start", busy, 1);
    endtask

    // Streams stim[0..n-1]; optional bubbles before odd elements and a stray start pulse
    task automatic applyStimulus(input int n, input bit bubbles, input int startAt);
        for (int i = 0; i < n; i++) begin
            if (bubbles && (i % 2 == 1)) begin
                in_valid = 1'b0;
                in_data = '1;
                tick();
            end
            in_valid = 1'b1;
            in_data = stim[i];
            start = (i == startAt);
            load_mat = (i == startAt);
            checkOutput($sformatf("in_ready[%0d]", i), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        start = 1'b0;
        load_mat = 1'b0;
    endtask

    task automatic waitResult(output int c);
        c = 0;
        while (!res_valid && c < 20) begin
            tick();
            c++;
        end
        checkOutput("res_valid rise", res_valid, 1);
    endtask

    task automatic readResult(input int expData, input int expIdx, input int hold,
                              input int expLat, input bit last, input bit pulseStart);
        int c;
        waitResult(c);
        if (expLat >= 0) checkOutput("latency", c, expLat);
        checkOutput("res_data", res_data, expData);
        checkOutput("res_idx", res_idx, expIdx);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            start = pulseStart;
            tick();
            start = 1'b0;
            checkOutput("hold res_valid", res_valid, 1);
            checkOutput("hold res_data", res_data, expData);
            checkOutput("hold res_idx", res_idx, expIdx);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput("res_valid after accept", res_valid, 0);
        if (last) begin
            checkOutput("done pulse", done, 1);
            checkOutput("busy idle", busy, 0);
            tick();
            checkOutput("done low", done, 0);
        end else begin
            checkOutput("done mid", done, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst in_ready", in_ready, 0);
        checkOutput("rst res_valid", res_valid, 0);
        checkOutput("rst res_data", res_data, 0);
        checkOutput("rst res_idx", res_idx, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);

        // Basic load of matrix and vector
        stim = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0};
        startOp(1'b1);
        applyStimulus(6, 1'b0, -1);
        readResult(17, 0, 0, 2, 1'b0, 1'b0);
        readResult(39, 1, 0, 2, 1'b1, 1'b0);

        // Matrix reuse; a third element offered during MAC must be refused
        stim = '{4'd1, 4'd1, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
        startOp(1'b0);
        applyStimulus(2, 1'b0, -1);
        in_valid = 1'b1;
        in_data = 4'd9;
        checkOutput("in_ready in MAC", in_ready, 0);
        readResult(3, 0, 0, 2, 1'b0, 1'b0);
        in_valid = 1'b0;
        readResult(7, 1, 0, 2, 1'b1, 1'b0);

        // Maximum operands
        stim = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0};
        startOp(1'b1);
        applyStimulus(6, 1'b0, -1);
        readResult(450, 0, 0, 2, 1'b0, 1'b0);
        readResult(450, 1, 0, 2, 1'b1, 1'b0);

        // Bubbles on input and 5 cycles of result backpressure
        stim = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0};
        startOp(1'b1);
        applyStimulus(6, 1'b1, -1);
        readResult(17, 0, 5, 2, 1'b0, 1'b0);
        readResult(39, 1, 0, 2, 1'b1, 1'b0);

        // Reset asserted while MAC is running
        startOp(1'b1);
        applyStimulus(6, 1'b0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst res_valid", res_valid, 0);
        checkOutput("midrst done", done, 0);
        tick();
        checkOutput("midrst no done", done, 0);
        checkOutput("midrst still idle", busy, 0);
        stim = '{4'd5, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        startOp(1'b0);
        applyStimulus(2, 1'b0, -1);
        readResult(0, 0, 0, 2, 1'b0, 1'b0);
        readResult(0, 1, 0, 2, 1'b1, 1'b0);

        // Start pulsed in LOAD_V and OUT, in_valid while IDLE
        stim = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0};
        startOp(1'b1);
        applyStimulus(6, 1'b0, 4);
        readResult(17, 0, 2, 2, 1'b0, 1'b1);
        readResult(39, 1, 0, 2, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data = 4'd9;
        for (int i = 0; i < 2; i++) begin
            checkOutput("in_ready idle", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        stim = '{4'd5, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        startOp(1'b0);
        applyStimulus(2, 1'b0, -1);
        readResult(17, 0, 0, 2, 1'b0, 1'b0);
        readResult(39, 1, 0, 2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
